cabac_bin_sched: RTL and testbench
==================================

# cabac_bin_sched

Sequences and shares the CABAC arithmetic-decoder state (ivlCurrRange/ivlOffset) among NUM_REQ syntax-element requesters, each bound 1:1 to a context-model bank of the `dec_bin_gt1_etc` type. It performs slice-start engine initialisation, grants one bank per bin with round-robin fairness, and holds the authoritative range/offset registers. It reports consumed bit counts to the bitstream reader, so `i_rbsp_in` at every bank is aligned before each issue.

## Interface
- NUM_REQ, 4: number of requesters/banks (2..8).
- CM_COUNT, 40: valid context indices per bank (0..CM_COUNT-1).
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i_start  in  1  pulse: begin slice, (re)initialise engine.
- i_req  in  NUM_REQ  bin request per requester.
- i_req_cm_idx  in  6*NUM_REQ  packed cm index; requester k at [6k+5:6k].
- o_gnt  out  NUM_REQ  one-hot, 1-cycle pulse: bin for requester k is on o_bin.
- o_bin  out  1  decoded bin, valid with o_gnt.
- o_ready  out  1  engine initialised and not busy.
- o_err  out  1  sticky error; cleared by rst or i_start.
- i_bank_init_done  in  NUM_REQ  bank context tables initialised.
- o_bank_dec_en  out  NUM_REQ  one-hot bank select (drives the bank's i_dec_en).
- o_bank_valid  out  1  issue strobe (drives every bank's i_valid).
- o_cm_idx  out  6  selected requester's cm index.
- o_ivlCurrRange  out  9  current range to all banks.
- o_ivlOffset  out  9  current offset to all banks.
- i_bank_binVal  in  NUM_REQ  per-bank bin.
- i_bank_len  in  3*NUM_REQ  per-bank renormalisation shift.
- i_bank_range  in  9*NUM_REQ  per-bank next range.
- i_bank_offset  in  9*NUM_REQ  per-bank next offset.
- i_bits_valid  in  1  bit reader aligned; rbsp/init bits valid.
- i_init_bits  in  9  next 9 bitstream bits, MSB first.
- o_consume  out  1  1-cycle pulse: advance reader.
- o_consume_len  out  4  bits to advance (0..9), valid with o_consume.

## Operation
- States: IDLE, WAIT_INIT, LOAD, READY, ISSUE, ADVANCE.
- IDLE: entered on rst. i_start moves to WAIT_INIT.
- WAIT_INIT: waits for i_bank_init_done all ones AND i_bits_valid, then moves to LOAD.
- LOAD (1 cycle): range←510, offset←i_init_bits. Pulses o_consume with len 9, then moves to READY.
- READY: o_ready=1. Waits for i_bits_valid and any i_req. Picks winner k by round-robin starting at ptr+1 mod NUM_REQ, then moves to ISSUE.
- ISSUE (1 cycle): o_bank_dec_en[k]=1, o_bank_valid=1, o_cm_idx=idx_k.
  - The bank outputs are combinational in this cycle. The scheduler captures range_k, offset_k, binVal_k and len_k at the closing edge, and sets ptr←k.
- ADVANCE (1 cycle): o_gnt[k]=1 and o_bin=captured bin. o_consume=1 with o_consume_len=len_k, zero-extended. Then moves to READY.
- Invalid index (idx_k ≥ CM_COUNT), detected in READY:
  - No bank enable is issued; range/offset are unchanged.
  - o_err is set. ADVANCE still pulses o_gnt[k] with o_bin=0 and o_consume_len=0, so the requester does not hang.
- Renorm check: if the captured range < 256, o_err is set. The value is still loaded; decoding continues.
- i_start in any state except IDLE: the current bin is aborted with no o_gnt. o_err is cleared, ptr is reset to NUM_REQ-1, and the FSM moves to WAIT_INIT.
  - An ADVANCE abort still completes that cycle's o_consume, to keep the reader consistent.
- Requesters hold i_req and the index until o_gnt. They may keep i_req high for back-to-back bins.

## Timing
- Reset values: o_gnt=0, o_bin=0, o_ready=0, o_err=0, o_bank_dec_en=0, o_bank_valid=0, o_cm_idx=0, o_ivlCurrRange=0, o_ivlOffset=0, o_consume=0, o_consume_len=0, ptr=NUM_REQ-1.
- Latency: request seen in READY → o_gnt 2 cycles later. Peak throughput is 1 bin per 3 cycles.
- o_ivlCurrRange/o_ivlOffset are registered; they change only at the LOAD or ISSUE closing edge.
- The bit reader must either present i_bits_valid=0 in the cycle after o_consume, or already reflect the advance. READY does not issue without i_bits_valid.
- All strobes (o_gnt, o_consume, o_bank_valid) are exactly 1 cycle wide. No two bank enables are ever asserted in the same cycle.
- If i_bank_init_done drops after LOAD, it is ignored until the next i_start.

## Test plan
- Init: rst, i_start, init_done=1111 with bits 9'h1A5 → LOAD cycle gives range=510, offset=0x1A5, o_consume_len=9, then o_ready=1.
- Round-robin: i_req=1111 held → o_gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
- Bank update: bank2 returns range=300, offset=77, len=1, bin=1 → o_gnt=0100, o_bin=1, o_consume_len=1; next o_ivlCurrRange=300, o_ivlOffset=77.
- Bit stall: i_bits_valid=0 for 5 cycles in READY → no o_bank_valid; issue occurs the cycle after i_bits_valid rises.
- Invalid index: idx=45 on requester 1 → o_err=1, o_gnt=0010 with o_bin=0, o_consume_len=0, no o_bank_dec_en; range/offset unchanged.
- Restart: i_start during ISSUE → no o_gnt, o_err cleared, FSM in WAIT_INIT. The next LOAD reloads range=510.

Source files
------------

// File: rtl/cabac_bin_sched.sv
// Shares one CABAC arithmetic-decoder state (range/offset) among NUM_REQ
// requester/context-bank pairs, issuing one bin at a time with round-robin fairness.
module cabac_bin_sched #(
    parameter int NUM_REQ  = 4,
    parameter int CM_COUNT = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [6*NUM_REQ-1:0]   i_req_cm_idx,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic                   o_bin,
    output logic                   o_ready,
    output logic                   o_err,
    input  logic [NUM_REQ-1:0]     i_bank_init_done,
    output logic [NUM_REQ-1:0]     o_bank_dec_en,
    output logic                   o_bank_valid,
    output logic [5:0]             o_cm_idx,
    output logic [8:0]             o_ivlCurrRange,
    output logic [8:0]             o_ivlOffset,
    input  logic [NUM_REQ-1:0]     i_bank_binVal,
    input  logic [3*NUM_REQ-1:0]   i_bank_len,
    input  logic [9*NUM_REQ-1:0]   i_bank_range,
    input  logic [9*NUM_REQ-1:0]   i_bank_offset,
    input  logic                   i_bits_valid,
    input  logic [8:0]             i_init_bits,
    output logic                   o_consume,
    output logic [3:0]             o_consume_len
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, LOAD, READY, ISSUE, ADVANCE
    } state_t;

    state_t state_reg, state_next;

    logic [5:0] cm_idx_arr [NUM_REQ];
    logic [2:0] len_arr    [NUM_REQ];
    logic [8:0] range_arr  [NUM_REQ];
    logic [8:0] offset_arr [NUM_REQ];
    logic [NUM_REQ-1:0] win_onehot;

    ptr_t       ptr_reg, win_reg, pick, cand_p;
    int         cand;
    logic       found, pick_inv;
    logic [5:0] idx_reg;
    logic       inv_reg, bin_reg, err_reg;
    logic [2:0] len_reg;
    logic [8:0] range_reg, offset_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign cm_idx_arr[gi] = i_req_cm_idx[6*gi +: 6];
            assign len_arr[gi]    = i_bank_len[3*gi +: 3];
            assign range_arr[gi]  = i_bank_range[9*gi +: 9];
            assign offset_arr[gi] = i_bank_offset[9*gi +: 9];
            assign win_onehot[gi] = (win_reg == ptr_t'(gi));
        end
    endgenerate

    // Search starts one past the last granted requester so every requester is served in turn.
    always_comb begin
        pick   = ptr_reg;
        found  = 1'b0;
        cand   = 0;
        cand_p = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand   = (int'(ptr_reg) + i) % NUM_REQ;
            cand_p = ptr_t'(cand);
            if (!found && i_req[cand_p]) begin
                found = 1'b1;
                pick  = cand_p;
            end
        end
        pick_inv = (int'(cm_idx_arr[pick]) >= CM_COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        o_gnt         = '0;
        o_bin         = 1'b0;
        o_ready       = 1'b0;
        o_bank_dec_en = '0;
        o_bank_valid  = 1'b0;
        o_cm_idx      = '0;
        o_consume     = 1'b0;
        o_consume_len = '0;
        case (state_reg)
            IDLE: begin
                if (i_start) state_next = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (!i_start && (&i_bank_init_done) && i_bits_valid) state_next = LOAD;
            end
            LOAD: begin
                if (i_start) begin
                    state_next = WAIT_INIT;
                end else begin
                    o_consume     = 1'b1;
                    o_consume_len = 4'd9;
                    state_next    = READY;
                end
            end
            READY: begin
                o_ready = 1'b1;
                if (i_start)                   state_next = WAIT_INIT;
                else if (i_bits_valid && found) state_next = ISSUE;
            end
            ISSUE: begin
                if (i_start) begin
                    state_next = WAIT_INIT;
                end else begin
                    o_bank_dec_en = inv_reg ? '0 : win_onehot;
                    o_bank_valid  = !inv_reg;
                    o_cm_idx      = idx_reg;
                    state_next    = ADVANCE;
                end
            end
            ADVANCE: begin
                // The reader advance completes even when the bin itself is aborted.
                o_consume     = 1'b1;
                o_consume_len = {1'b0, len_reg};
                if (i_start) begin
                    state_next = WAIT_INIT;
                end else begin
                    o_gnt      = win_onehot;
                    o_bin      = bin_reg;
                    state_next = READY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg    <= ptr_t'(NUM_REQ - 1);
            win_reg    <= '0;
            idx_reg    <= '0;
            inv_reg    <= 1'b0;
            bin_reg    <= 1'b0;
            len_reg    <= '0;
            err_reg    <= 1'b0;
            range_reg  <= '0;
            offset_reg <= '0;
        end else if (i_start) begin
            err_reg <= 1'b0;
            ptr_reg <= ptr_t'(NUM_REQ - 1);
        end else begin
            case (state_reg)
                LOAD: begin
                    range_reg  <= 9'd510;
                    offset_reg <= i_init_bits;
                end
                READY: begin
                    if (i_bits_valid && found) begin
                        win_reg <= pick;
                        idx_reg <= cm_idx_arr[pick];
                        inv_reg <= pick_inv;
                        if (pick_inv) err_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    ptr_reg <= win_reg;
                    if (inv_reg) begin
                        bin_reg <= 1'b0;
                        len_reg <= '0;
                    end else begin
                        range_reg  <= range_arr[win_reg];
                        offset_reg <= offset_arr[win_reg];
                        bin_reg    <= i_bank_binVal[win_reg];
                        len_reg    <= len_arr[win_reg];
                        // A bank returning an unnormalised range means its renorm logic is broken.
                        if (range_arr[win_reg] < 9'd256) err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err          = err_reg;
    assign o_ivlCurrRange = range_reg;
    assign o_ivlOffset    = offset_reg;
endmodule

// File: tb/tb_cabac_bin_sched.sv
// Scoreboarded directed bench for cabac_bin_sched: the stimulus queues expected
// consume/grant and bank-issue transactions, a negedge monitor checks them.
module tb_cabac_bin_sched;
    logic             clk = 1'b0;
    logic             rst, i_start;
    logic [3:0]       i_req;
    logic [3:0][5:0]  b_idx;
    logic [3:0]       o_gnt;
    logic             o_bin, o_ready, o_err;
    logic [3:0]       i_bank_init_done;
    logic [3:0]       o_bank_dec_en;
    logic             o_bank_valid;
    logic [5:0]       o_cm_idx;
    logic [8:0]       o_ivlCurrRange, o_ivlOffset;
    logic [3:0]       b_bin;
    logic [3:0][2:0]  b_len;
    logic [3:0][8:0]  b_range, b_offset;
    logic             i_bits_valid;
    logic [8:0]       i_init_bits;
    logic             o_consume;
    logic [3:0]       o_consume_len;

    typedef struct packed { logic [3:0] gnt; logic bin; logic [3:0] len; } exp_t;
    typedef struct packed { logic [3:0] en; logic [5:0] idx; } bank_t;
    exp_t  exp_q [$];
    bank_t bank_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    cabac_bin_sched #(.NUM_REQ(4), .CM_COUNT(40)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_req(i_req),
        .i_req_cm_idx(b_idx), .o_gnt(o_gnt), .o_bin(o_bin), .o_ready(o_ready),
        .o_err(o_err), .i_bank_init_done(i_bank_init_done),
        .o_bank_dec_en(o_bank_dec_en), .o_bank_valid(o_bank_valid),
        .o_cm_idx(o_cm_idx), .o_ivlCurrRange(o_ivlCurrRange),
        .o_ivlOffset(o_ivlOffset), .i_bank_binVal(b_bin), .i_bank_len(b_len),
        .i_bank_range(b_range), .i_bank_offset(b_offset),
        .i_bits_valid(i_bits_valid), .i_init_bits(i_init_bits),
        .o_consume(o_consume), .o_consume_len(o_consume_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every consume (LOAD or ADVANCE) and every bank issue is a transaction.
    initial begin
        exp_t e;
        bank_t b;
        forever begin
            @(negedge clk);
            if (o_consume) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_consume", {o_gnt, o_bin, o_consume_len}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn t=%0t gnt=%b bin=%0d len=%0d", $time, o_gnt, o_bin, o_consume_len);
                    chk("txn_gnt", {28'd0, o_gnt}, {28'd0, e.gnt});
                    chk("txn_bin", {31'd0, o_bin}, {31'd0, e.bin});
                    chk("txn_len", {28'd0, o_consume_len}, {28'd0, e.len});
                end
            end else if (o_gnt != 4'd0) begin
                chk("gnt_without_consume", {28'd0, o_gnt}, 32'd0);
            end
            if (o_bank_valid) begin
                if (bank_q.size() == 0) begin
                    chk("unexpected_bank_issue", {22'd0, o_bank_dec_en, o_cm_idx}, 32'hFFFF);
                end else begin
                    b = bank_q.pop_front();
                    $display("issue t=%0t dec_en=%b cm_idx=%0d", $time, o_bank_dec_en, o_cm_idx);
                    chk("issue_dec_en", {28'd0, o_bank_dec_en}, {28'd0, b.en});
                    chk("issue_cm_idx", {26'd0, o_cm_idx}, {26'd0, b.idx});
                end
            end else if (o_bank_dec_en != 4'd0) begin
                chk("dec_en_without_valid", {28'd0, o_bank_dec_en}, 32'd0);
            end
        end
    end

    task automatic wait_gnt();
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_gnt != 4'd0) got = 1;
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_ready) got = 1;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcyc [5];
        bit seen;
        rst = 1'b1; i_start = 1'b0; i_req = '0; i_bits_valid = 1'b0;
        i_init_bits = '0; i_bank_init_done = '0; b_bin = '0;
        for (int k = 0; k < 4; k++) begin
            b_idx[k]    = 6'(k + 1);
            b_range[k]  = 9'(256 + 16 * k);
            b_offset[k] = 9'(10 + k);
            b_len[k]    = 3'(k);
            b_bin[k]    = k[0];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt", {28'd0, o_gnt}, 32'd0);
        chk("reset_ready", {31'd0, o_ready}, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);
        chk("reset_range", {23'd0, o_ivlCurrRange}, 32'd0);
        chk("reset_offset", {23'd0, o_ivlOffset}, 32'd0);
        chk("reset_strobes", {30'd0, o_consume, o_bank_valid}, 32'd0);

        // Slice init: LOAD consumes 9 bits, range=510, offset=init bits
        exp_q.push_back('{gnt: 4'b0000, bin: 1'b0, len: 4'd9});
        @(posedge clk); #1;
        i_bank_init_done = 4'b1111; i_bits_valid = 1'b1; i_init_bits = 9'h1A5;
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        wait_ready();
        chk("init_range", {23'd0, o_ivlCurrRange}, 32'd510);
        chk("init_offset", {23'd0, o_ivlOffset}, 32'h1A5);

        // Round-robin with all requesters held: 0,1,2,3,0
        exp_q.push_back('{gnt: 4'b0001, bin: 1'b0, len: 4'd0});
        exp_q.push_back('{gnt: 4'b0010, bin: 1'b1, len: 4'd1});
        exp_q.push_back('{gnt: 4'b0100, bin: 1'b0, len: 4'd2});
        exp_q.push_back('{gnt: 4'b1000, bin: 1'b1, len: 4'd3});
        exp_q.push_back('{gnt: 4'b0001, bin: 1'b0, len: 4'd0});
        bank_q.push_back('{en: 4'b0001, idx: 6'd1});
        bank_q.push_back('{en: 4'b0010, idx: 6'd2});
        bank_q.push_back('{en: 4'b0100, idx: 6'd3});
        bank_q.push_back('{en: 4'b1000, idx: 6'd4});
        bank_q.push_back('{en: 4'b0001, idx: 6'd1});
        @(posedge clk); #1 i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt();
            gcyc[g] = cyc;
        end
        i_req = 4'b0000;
        for (int g = 1; g < 5; g++) chk("rr_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'd3);
        chk("rr_range", {23'd0, o_ivlCurrRange}, 32'd256);
        chk("rr_offset", {23'd0, o_ivlOffset}, 32'd10);

        // Bank 2 update
        @(posedge clk); #1;
        b_range[2] = 9'd300; b_offset[2] = 9'd77; b_len[2] = 3'd1; b_bin[2] = 1'b1;
        exp_q.push_back('{gnt: 4'b0100, bin: 1'b1, len: 4'd1});
        bank_q.push_back('{en: 4'b0100, idx: 6'd3});
        i_req = 4'b0100;
        wait_gnt();
        i_req = 4'b0000;
        chk("upd_range", {23'd0, o_ivlCurrRange}, 32'd300);
        chk("upd_offset", {23'd0, o_ivlOffset}, 32'd77);

        // Bit stall: no issue while i_bits_valid is low
        @(posedge clk); #1;
        i_bits_valid = 1'b0; i_req = 4'b0001;
        exp_q.push_back('{gnt: 4'b0001, bin: 1'b0, len: 4'd0});
        bank_q.push_back('{en: 4'b0001, idx: 6'd1});
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_bank_valid) seen = 1;
        end
        chk("stall_no_issue", {31'd0, seen}, 32'd0);
        @(posedge clk); #1 i_bits_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready_cycle", {31'd0, o_bank_valid}, 32'd0);
        @(negedge clk);
        chk("stall_issue_next", {31'd0, o_bank_valid}, 32'd1);
        wait_gnt();
        i_req = 4'b0000;
        chk("stall_range", {23'd0, o_ivlCurrRange}, 32'd256);

        // Invalid index on requester 1: no bank issue, bin 0, len 0, error set
        @(posedge clk); #1;
        b_idx[1] = 6'd45; b_range[1] = 9'd400; b_bin[1] = 1'b1; b_len[1] = 3'd5;
        exp_q.push_back('{gnt: 4'b0010, bin: 1'b0, len: 4'd0});
        i_req = 4'b0010;
        wait_gnt();
        i_req = 4'b0000;
        chk("inv_err", {31'd0, o_err}, 32'd1);
        chk("inv_range", {23'd0, o_ivlCurrRange}, 32'd256);
        chk("inv_offset", {23'd0, o_ivlOffset}, 32'd10);

        // Restart during ISSUE of requester 3
        @(posedge clk); #1;
        b_idx[1] = 6'd2; b_idx[3] = 6'd7;
        i_req = 4'b1000;
        @(posedge clk); #1;
        i_start = 1'b1; i_req = 4'b0000; i_bank_init_done = 4'b0000;
        @(posedge clk); #1 i_start = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_ready || o_gnt != 4'd0) seen = 1;
        end
        chk("restart_idle", {31'd0, seen}, 32'd0);
        chk("restart_err_clr", {31'd0, o_err}, 32'd0);
        chk("restart_range_kept", {23'd0, o_ivlCurrRange}, 32'd256);
        exp_q.push_back('{gnt: 4'b0000, bin: 1'b0, len: 4'd9});
        @(posedge clk); #1 i_init_bits = 9'h0F3; i_bank_init_done = 4'b1111;
        wait_ready();
        chk("reload_range", {23'd0, o_ivlCurrRange}, 32'd510);
        chk("reload_offset", {23'd0, o_ivlOffset}, 32'h0F3);

        // Pointer was reset to 3, so requester 0 wins first
        exp_q.push_back('{gnt: 4'b0001, bin: 1'b0, len: 4'd0});
        bank_q.push_back('{en: 4'b0001, idx: 6'd1});
        @(posedge clk); #1 i_req = 4'b1111;
        wait_gnt();
        i_req = 4'b0000;
        chk("post_restart_range", {23'd0, o_ivlCurrRange}, 32'd256);

        repeat (5) @(negedge clk);
        chk("queues_drained", 32'(exp_q.size() + bank_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
